fifo_drain_tx: RTL and testbench
================================

Name: fifo_drain_tx

Overview:
- Read-side controller for the ADC capture FIFO; the capture controller fills the FIFO and waits for it to go empty.
- On start, sends a sync byte, then reads the FIFO one word at a time. Each word goes out MSB byte first on an 8-bit valid/ready byte stream, for example into the UART TX.
- Finishes when the FIFO is empty at a word boundary and pulses drain_done.

Parameters:
DATA_W, 16, FIFO word width; must be a multiple of 8; BYTES = DATA_W/8
SYNC_BYTE, 8'hA5, frame header byte sent at the start of every drain
CNT_W, 16, width of word_count

Ports:
clk  input  1  system clock
rstn  input  1  reset, asynchronous, active-low
start  input  1  level; begins a drain when sampled high in IDLE
fifo_empty  input  1  FIFO empty flag
fifo_dout  input  DATA_W  FIFO read data, valid 1 cycle after fifo_rd_en (standard-mode FIFO)
fifo_rd_en  output  1  FIFO read strobe, one cycle per word
tx_data  output  8  byte to transmitter
tx_valid  output  1  tx_data valid
tx_ready  input  1  transmitter accepts byte when tx_valid && tx_ready
busy  output  1  high in every state except IDLE
drain_done  output  1  one-cycle pulse at end of drain
word_count  output  CNT_W  words sent in the current/last drain, saturating
state  output  3  current state code, for debug/ILA

Behaviour:
- Reset (async, rstn=0): state=IDLE, fifo_rd_en=0, tx_valid=0, tx_data=0, busy=0, drain_done=0, word_count=0. Shift register and byte counter cleared. All outputs drop immediately, without waiting for a clock edge.
- State codes: IDLE=0, HDR=1, FETCH=2, LOAD=3, SEND=4, DONE=5. Codes 6 and 7 go to IDLE.
- Moore outputs from registered state, except fifo_rd_en = (state==FETCH) && !fifo_empty.
- IDLE:
  - start=1 -> HDR; word_count cleared to 0 on this transition.
  - start=0 -> stay in IDLE.
- HDR:
  - tx_valid=1, tx_data=SYNC_BYTE.
  - On handshake -> FETCH.
- FETCH (1 cycle):
  - If !fifo_empty: fifo_rd_en=1 -> LOAD.
  - Else -> DONE; no read is issued.
- LOAD (1 cycle): shreg <= fifo_dout, bytes_left <= BYTES -> SEND.
- SEND:
  - tx_valid=1, tx_data=shreg[DATA_W-1 -: 8].
  - On handshake: shreg shifts left by 8 and bytes_left decrements.
  - When the last byte is accepted: word_count increments (saturates at all ones) -> FETCH.
- DONE: drain_done=1 for exactly one cycle -> IDLE.
- Handshake rules:
  - tx_data and tx_valid hold stable while tx_valid && !tx_ready.
  - tx_valid never deasserts without a handshake, except on reset.
  - tx_data=0 whenever tx_valid=0.
- Latency:
  - start high -> header valid: 1 cycle.
  - Last byte accepted -> next word's first byte valid: 3 cycles (FETCH, LOAD, SEND).
- FIFO boundaries:
  - No read is ever issued while fifo_empty=1, so FIFO underflow cannot occur.
  - fifo_empty is sampled only in FETCH.
  - A word arriving during SEND is picked up at the next FETCH.
- start while busy is ignored.
- start held high through DONE starts a new drain: DONE -> IDLE -> HDR.
- An empty FIFO at start produces a header-only frame with word_count=0.
- Reset mid-frame abandons the partial word; the FIFO is not rewound.

Test Plan:
- Reset: assert rstn=0 mid-SEND -> tx_valid=0, busy=0, state=0 before the next clk edge. After release, no output until start.
- Normal drain: FIFO holds 16'h1234, 16'hABCD, 16'h00FF; tx_ready=1; pulse start -> byte stream A5 12 34 AB CD 00 FF. Exactly 3 fifo_rd_en pulses, word_count=3, one drain_done pulse, then IDLE.
- Empty FIFO: fifo_empty=1, start -> single byte A5, no fifo_rd_en, drain_done pulse, word_count=0.
- Backpressure: same data with tx_ready low for 5 cycles after byte 0x12 and toggling afterwards -> tx_data stays 0x12 while stalled. No extra rd_en, no byte lost or duplicated, same 7-byte stream.
- Late data: FIFO holds 1 word; push a second word during SEND -> both words sent; drain_done only after the second word's last byte.
- Continuous start: start held at 1 with FIFO holding 1 word -> frame A5 xx xx, DONE, IDLE, then a new A5 header 2 cycles after drain_done. word_count resets to 0 at the new frame.

Source files
------------

// File: rtl/fifo_drain_tx.sv
// Drains the ADC capture FIFO onto an 8-bit valid/ready byte stream:
// a sync byte, then each FIFO word MSB byte first, then a one-cycle done pulse.
module fifo_drain_tx #(
  parameter int         DATA_W    = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              drain_done,
  output logic [CNT_W-1:0]  word_count,
  output logic [2:0]        state
);

  localparam int BYTES = DATA_W / 8;
  localparam int BCW   = $clog2(BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_FETCH = 3'd2,
    S_LOAD  = 3'd3,
    S_SEND  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]    bytes_q, bytes_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      bytes_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bytes_q <= bytes_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bytes_d = bytes_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_HDR;
        cnt_d   = '0;
      end
      S_HDR:   if (tx_ready) state_d = S_FETCH;
      // fifo_empty is only looked at here, so a word landing mid-SEND waits for the next FETCH
      S_FETCH: state_d = fifo_empty ? S_DONE : S_LOAD;
      S_LOAD: begin
        shreg_d = fifo_dout;
        bytes_d = BCW'(BYTES);
        state_d = S_SEND;
      end
      S_SEND: if (tx_ready) begin
        shreg_d = shreg_q << 8;
        bytes_d = bytes_q - 1'b1;
        if (bytes_q == BCW'(1)) begin
          state_d = S_FETCH;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
      end
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = shreg_q[DATA_W-1 -: 8];
      end
      default: ;
    endcase
  end

  assign fifo_rd_en = (state_q == S_FETCH) && !fifo_empty;
  assign busy       = (state_q != S_IDLE);
  assign drain_done = (state_q == S_DONE);
  assign word_count = cnt_q;
  assign state      = state_q;

endmodule

// File: tb/tb_fifo_drain_tx.sv
// Scoreboarded bench for fifo_drain_tx: expected bytes are queued by the
// stimulus, a negedge monitor pops and compares on every accepted byte.
module tb_fifo_drain_tx;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        fifo_empty;
  logic [15:0] fifo_dout = 16'h0000;
  logic        fifo_rd_en;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        drain_done;
  logic [15:0] word_count;
  logic [2:0]  state;

  int n_chk  = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int done_cnt = 0;

  logic [7:0]  exp_q[$];
  logic [15:0] mem [0:31];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        flush = 1'b0;

  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  always #5 clk = ~clk;

  fifo_drain_tx #(.DATA_W(16), .SYNC_BYTE(8'hA5), .CNT_W(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .drain_done (drain_done),
    .word_count (word_count),
    .state      (state)
  );

  // standard-mode FIFO model: data appears the cycle after the read strobe
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr % 32];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rstn) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        check("stall_valid_held", 32'(tx_valid), 32'd1);
        check("stall_data_held", 32'(tx_data), 32'(prev_data));
      end
      if (!tx_valid) check("idle_data_zero", 32'(tx_data), 32'd0);
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_byte: got %h, none expected at %0t", tx_data, $time);
        end else check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      if (fifo_rd_en) rd_cnt++;
      if (drain_done) done_cnt++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_word(input logic [15:0] w);
    mem[wr_ptr % 32] = w;
    wr_ptr++;
  endtask

  task automatic expect_bytes(input logic [15:0] w);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic pulse_start();
    step(); start = 1'b1;
    step(); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int k;
    k = 0;
    while (!drain_done && k < budget) begin
      step();
      k++;
    end
    if (!drain_done) fail_now({nm, "_timeout"});
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
    int k;
    k = 0;
    while (state !== s && k < budget) begin
      step();
      k++;
    end
    if (state !== s) fail_now({nm, "_timeout"});
  endtask

  initial begin
    int rd0, d0, stall, k;
    logic seen;
    rstn = 1'b0; start = 1'b0; tx_ready = 1'b1;

    // reset state
    #12;
    check("rst_state", 32'(state), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_done", 32'(drain_done), 32'd0);
    check("rst_wc", 32'(word_count), 32'd0);
    step(); rstn = 1'b1;
    repeat (3) step();
    check("idle_state", 32'(state), 32'd0);
    check("idle_valid", 32'(tx_valid), 32'd0);

    // normal drain
    push_word(16'h1234); push_word(16'hABCD); push_word(16'h00FF);
    exp_q.push_back(8'hA5);
    expect_bytes(16'h1234); expect_bytes(16'hABCD); expect_bytes(16'h00FF);
    rd0 = rd_cnt; d0 = done_cnt;
    pulse_start();
    wait_done(100, "normal");
    check("normal_wc", 32'(word_count), 32'd3);
    step();
    check("normal_idle", 32'(state), 32'd0);
    check("normal_rd", 32'(rd_cnt - rd0), 32'd3);
    check("normal_done", 32'(done_cnt - d0), 32'd1);
    check("normal_left", 32'(exp_q.size()), 32'd0);

    // empty FIFO: header-only frame
    exp_q.push_back(8'hA5);
    rd0 = rd_cnt; d0 = done_cnt;
    pulse_start();
    wait_done(50, "empty");
    check("empty_wc", 32'(word_count), 32'd0);
    step();
    check("empty_rd", 32'(rd_cnt - rd0), 32'd0);
    check("empty_done", 32'(done_cnt - d0), 32'd1);
    check("empty_left", 32'(exp_q.size()), 32'd0);

    // backpressure: 5 cycles stalled on 0x12, then toggling ready
    push_word(16'h1234); push_word(16'hABCD); push_word(16'h00FF);
    exp_q.push_back(8'hA5);
    expect_bytes(16'h1234); expect_bytes(16'hABCD); expect_bytes(16'h00FF);
    rd0 = rd_cnt; d0 = done_cnt;
    pulse_start();
    seen = 1'b0; stall = 0; k = 0;
    while (!drain_done && k < 200) begin
      if (!seen && tx_valid && tx_data == 8'h12) begin
        seen = 1'b1; stall = 5; tx_ready = 1'b0;
      end else if (stall > 0) begin
        stall--;
        tx_ready = (stall == 0);
      end else if (seen) tx_ready = ~tx_ready;
      step();
      k++;
    end
    if (!drain_done) fail_now("bp_timeout");
    check("bp_seen12", 32'(seen), 32'd1);
    tx_ready = 1'b1;
    step();
    check("bp_rd", 32'(rd_cnt - rd0), 32'd3);
    check("bp_done", 32'(done_cnt - d0), 32'd1);
    check("bp_left", 32'(exp_q.size()), 32'd0);
    check("bp_wc", 32'(word_count), 32'd3);

    // late data: second word pushed while the first is being sent
    push_word(16'h5A3C);
    exp_q.push_back(8'hA5);
    expect_bytes(16'h5A3C); expect_bytes(16'hC396);
    rd0 = rd_cnt;
    pulse_start();
    wait_state(3'd4, 20, "late_send");
    push_word(16'hC396);
    wait_done(100, "late");
    check("late_left_at_done", 32'(exp_q.size()), 32'd0);
    check("late_wc", 32'(word_count), 32'd2);
    step();
    check("late_rd", 32'(rd_cnt - rd0), 32'd2);

    // continuous start: DONE -> IDLE -> HDR
    push_word(16'h7E81);
    exp_q.push_back(8'hA5);
    expect_bytes(16'h7E81);
    exp_q.push_back(8'hA5);
    step(); start = 1'b1;
    wait_done(50, "cont");
    check("cont_wc1", 32'(word_count), 32'd1);
    step();
    check("cont_idle", 32'(state), 32'd0);
    step();
    check("cont_hdr_state", 32'(state), 32'd1);
    check("cont_hdr_valid", 32'(tx_valid), 32'd1);
    check("cont_hdr_data", 32'(tx_data), 32'hA5);
    check("cont_wc_clr", 32'(word_count), 32'd0);
    start = 1'b0;
    wait_done(50, "cont2");
    step();
    check("cont_left", 32'(exp_q.size()), 32'd0);

    // async reset mid-SEND
    push_word(16'hDEAD); push_word(16'hBEEF);
    exp_q.push_back(8'hA5); exp_q.push_back(8'hDE);
    pulse_start();
    k = 0;
    while (!(state == 3'd4 && tx_data == 8'hAD) && k < 50) begin
      step();
      k++;
    end
    if (!(state == 3'd4 && tx_data == 8'hAD)) fail_now("mid_send_timeout");
    tx_ready = 1'b0;
    #1 rstn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_data", 32'(tx_data), 32'd0);
    check("mid_rst_wc", 32'(word_count), 32'd0);
    step(); flush = 1'b1; tx_ready = 1'b1;
    step(); flush = 1'b0; rstn = 1'b1;
    repeat (4) step();
    check("post_rst_state", 32'(state), 32'd0);
    check("post_rst_valid", 32'(tx_valid), 32'd0);
    check("post_rst_left", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
